go_done_initiator: RTL



---
 rtl/go_done_initiator.sv | 132 +++++++++++++
 1 files changed

// File: rtl/go_done_initiator.sv
// Initiator for the go/done start handshake: takes jobs from a valid/ready stream,
// pulses go to a single-job worker, waits for done with a timeout and returns the result.
module go_done_initiator #(
  parameter int IN_WIDTH       = 32,
  parameter int OUT_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 160,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 go,
  output logic [IN_WIDTH-1:0]  worker_in,
  input  logic                 done,
  input  logic [OUT_WIDTH-1:0] worker_out,
  output logic                 res_valid,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic                 res_timeout,
  input  logic                 res_ready,
  output logic [CNT_WIDTH-1:0] jobs_ok,
  output logic [CNT_WIDTH-1:0] jobs_timeout,
  output logic                 protocol_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GO, S_WAIT, S_RESULT} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IN_WIDTH-1:0]  worker_in_q, worker_in_d;
  logic                 res_valid_q, res_valid_d;
  logic [OUT_WIDTH-1:0] res_data_q, res_data_d;
  logic                 res_timeout_q, res_timeout_d;
  logic [CNT_WIDTH-1:0] jobs_ok_q, jobs_ok_d;
  logic [CNT_WIDTH-1:0] jobs_to_q, jobs_to_d;
  logic                 perr_q, perr_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      worker_in_q   <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      jobs_ok_q     <= '0;
      jobs_to_q     <= '0;
      perr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      worker_in_q   <= worker_in_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      jobs_ok_q     <= jobs_ok_d;
      jobs_to_q     <= jobs_to_d;
      perr_q        <= perr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    worker_in_d   = worker_in_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    jobs_ok_d     = jobs_ok_q;
    jobs_to_d     = jobs_to_q;
    perr_d        = perr_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          worker_in_d = in_data;
          state_d     = S_GO;
        end
      end
      S_GO: begin
        // done seen at this edge predates the go pulse, so it is not looked at
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q == '0 && done) begin
          perr_d  = 1'b1;
          timer_d = timer_q + TW'(1);
        end else if (done) begin
          res_data_d    = worker_out;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          jobs_ok_d     = sat_inc(jobs_ok_q);
          state_d       = S_RESULT;
        end else if (timer_q == T_LAST) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          jobs_to_d     = sat_inc(jobs_to_q);
          state_d       = S_RESULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign go           = (state_q == S_GO);
  assign worker_in    = worker_in_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_timeout  = res_timeout_q;
  assign jobs_ok      = jobs_ok_q;
  assign jobs_timeout = jobs_to_q;
  assign protocol_err = perr_q;

endmodule
